// File: rtl/mem_arb_pkg.sv
// Shared types and bus encodings for the icache/dcache memory-port arbiter.
package mem_arb_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef enum logic {OWN_ICACHE = 1'b0, OWN_DCACHE = 1'b1} mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tracks which cache owns each outstanding memory tag; a set and a clear of
// the same tag in one cycle leaves the entry valid with the new owner.
module mem_tag_owner_table
  import mem_arb_pkg::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output logic             lookup_owner
);

  tag_entry_t entry [1:NUM_TAGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        entry[i] <= '{valid: 1'b0, owner: OWN_ICACHE};
      end
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (set_en && set_tag == TAG_W'(i)) begin
          entry[i] <= '{valid: 1'b1, owner: mem_owner_t'(set_owner)};
        end else if (clr_en && clr_tag == TAG_W'(i)) begin
          entry[i].valid <= 1'b0;
        end
      end
    end
  end

  // Tag 0 matches no entry, so it always reads as invalid.
  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWN_ICACHE;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (lookup_tag == TAG_W'(i)) begin
        lookup_valid = entry[i].valid;
        lookup_owner = entry[i].owner;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory port between icache and dcache: zero-latency grant,
// starvation guard for the icache, and return-tag steering to the owning cache.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      Icache2mem_command,
  input  logic [XLEN-1:0] Icache2mem_addr,
  input  logic [1:0]      Dcache2mem_command,
  input  logic [XLEN-1:0] Dcache2mem_addr,
  input  logic [63:0]     Dcache2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] starve_cnt;
  logic             i_req;
  logic             d_req;
  logic             grant_icache;
  logic             grant_dcache;
  logic             accept_load;
  logic             lookup_valid;
  logic             lookup_owner;

  assign i_req = (Icache2mem_command != BUS_NONE);
  assign d_req = (Dcache2mem_command != BUS_NONE);

  // Grants are forced low in reset so every bus-facing output reads idle at once.
  always_comb begin
    grant_icache = 1'b0;
    grant_dcache = 1'b0;
    if (reset_n) begin
      if (i_req && d_req) begin
        if (starve_cnt == STARVE_MAX) grant_icache = 1'b1;
        else                          grant_dcache = 1'b1;
      end else if (i_req) begin
        grant_icache = 1'b1;
      end else if (d_req) begin
        grant_dcache = 1'b1;
      end
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_icache) begin
      proc2mem_command = Icache2mem_command;
      proc2mem_addr    = Icache2mem_addr;
    end else if (grant_dcache) begin
      proc2mem_command = Dcache2mem_command;
      proc2mem_addr    = Dcache2mem_addr;
      if (Dcache2mem_command == BUS_STORE) proc2mem_data = Dcache2mem_data;
    end
  end

  assign Imem2proc_response = grant_icache ? mem2proc_response : 4'd0;
  assign Dmem2proc_response = grant_dcache ? mem2proc_response : 4'd0;
  assign Imem2proc_data     = mem2proc_data;
  assign Dmem2proc_data     = mem2proc_data;

  // A rejected grant to the dcache still counts as a denial for the icache.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!i_req || (grant_icache && mem2proc_response != 4'd0)) begin
      starve_cnt <= '0;
    end else if (!grant_icache) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  assign accept_load = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock        (clock),
    .reset_n      (reset_n),
    .set_en       (accept_load),
    .set_tag      (mem2proc_response),
    .set_owner    (grant_dcache),
    .clr_en       (mem2proc_tag != 4'd0),
    .clr_tag      (mem2proc_tag),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner)
  );

  assign Imem2proc_tag = (reset_n && lookup_valid && lookup_owner == OWN_ICACHE) ? mem2proc_tag : 4'd0;
  assign Dmem2proc_tag = (reset_n && lookup_valid && lookup_owner == OWN_DCACHE) ? mem2proc_tag : 4'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant, starvation, store, tag steering and reset.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [1:0]      Icache2mem_command;
  logic [XLEN-1:0] Icache2mem_addr;
  logic [1:0]      Dcache2mem_command;
  logic [XLEN-1:0] Dcache2mem_addr;
  logic [63:0]     Dcache2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      Imem2proc_response;
  logic [63:0]     Imem2proc_data;
  logic [3:0]      Imem2proc_tag;
  logic [3:0]      Dmem2proc_response;
  logic [63:0]     Dmem2proc_data;
  logic [3:0]      Dmem2proc_tag;

  int tests  = 0;
  int failed = 0;

  mem_bus_arbiter dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .Icache2mem_command (Icache2mem_command),
    .Icache2mem_addr    (Icache2mem_addr),
    .Dcache2mem_command (Dcache2mem_command),
    .Dcache2mem_addr    (Dcache2mem_addr),
    .Dcache2mem_data    (Dcache2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    Icache2mem_command = BUS_NONE;
    Icache2mem_addr    = '0;
    Dcache2mem_command = BUS_NONE;
    Dcache2mem_addr    = '0;
    Dcache2mem_data    = '0;
    mem2proc_response  = 4'd0;
    mem2proc_data      = 64'h0123_4567_89AB_CDEF;
    mem2proc_tag       = 4'd0;
  endtask

  task automatic both_load(input logic [3:0] resp);
    Icache2mem_command = BUS_LOAD;
    Icache2mem_addr    = 32'h108;
    Dcache2mem_command = BUS_LOAD;
    Dcache2mem_addr    = 32'h300;
    mem2proc_response  = resp;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    // Requests presented while in reset must be ignored.
    Icache2mem_command = BUS_LOAD;
    Icache2mem_addr    = 32'h100;
    mem2proc_response  = 4'd3;
    #2;
    chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_addr", 64'(proc2mem_addr), 64'h0);
    chk("rst_iresp", 64'(Imem2proc_response), 64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    idle();
    tick();

    // Icache-only load, tag 3 returns five cycles later.
    Icache2mem_command = BUS_LOAD;
    Icache2mem_addr    = 32'h100;
    mem2proc_response  = 4'd3;
    #1;
    chk("i_only_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("i_only_addr", 64'(proc2mem_addr), 64'h100);
    chk("i_only_iresp", 64'(Imem2proc_response), 64'd3);
    chk("i_only_dresp", 64'(Dmem2proc_response), 64'd0);
    chk("i_only_data0", proc2mem_data, 64'h0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    mem2proc_tag = 4'd3;
    #1;
    chk("ret3_itag", 64'(Imem2proc_tag), 64'd3);
    chk("ret3_dtag", 64'(Dmem2proc_tag), 64'd0);
    chk("ret3_idata", Imem2proc_data, 64'h0123_4567_89AB_CDEF);
    tick();
    mem2proc_tag = 4'd3;
    #1;
    chk("stale3_itag", 64'(Imem2proc_tag), 64'd0);
    chk("stale3_dtag", 64'(Dmem2proc_tag), 64'd0);
    tick();
    idle();

    // Contention: dcache wins four times, then the icache is let through.
    both_load(4'd2);
    #1;
    chk("cont1_addr", 64'(proc2mem_addr), 64'h300);
    chk("cont1_dresp", 64'(Dmem2proc_response), 64'd2);
    chk("cont1_iresp", 64'(Imem2proc_response), 64'd0);
    chk("cont1_data0", proc2mem_data, 64'h0);
    tick();
    for (int k = 2; k <= 4; k++) begin
      both_load(4'd0);
      #1;
      chk($sformatf("cont%0d_addr", k), 64'(proc2mem_addr), 64'h300);
      tick();
    end
    both_load(4'd5);
    #1;
    chk("cont5_addr", 64'(proc2mem_addr), 64'h108);
    chk("cont5_iresp", 64'(Imem2proc_response), 64'd5);
    chk("cont5_dresp", 64'(Dmem2proc_response), 64'd0);
    tick();
    both_load(4'd0);
    #1;
    chk("cont6_cleared", 64'(proc2mem_addr), 64'h300);
    tick();
    idle();
    mem2proc_tag = 4'd2;
    #1;
    chk("ret2_dtag", 64'(Dmem2proc_tag), 64'd2);
    chk("ret2_itag", 64'(Imem2proc_tag), 64'd0);
    tick();
    mem2proc_tag = 4'd5;
    #1;
    chk("ret5_itag", 64'(Imem2proc_tag), 64'd5);
    chk("ret5_dtag", 64'(Dmem2proc_tag), 64'd0);
    tick();
    idle();

    // Dcache store records no owner.
    Dcache2mem_command = BUS_STORE;
    Dcache2mem_addr    = 32'h200;
    Dcache2mem_data    = 64'hDEAD;
    mem2proc_response  = 4'd7;
    #1;
    chk("st_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("st_addr", 64'(proc2mem_addr), 64'h200);
    chk("st_data", proc2mem_data, 64'hDEAD);
    chk("st_dresp", 64'(Dmem2proc_response), 64'd7);
    tick();
    idle();
    mem2proc_tag = 4'd7;
    #1;
    chk("ret7_itag", 64'(Imem2proc_tag), 64'd0);
    chk("ret7_dtag", 64'(Dmem2proc_tag), 64'd0);
    tick();
    idle();

    // Tag 4 returns to icache in the same cycle dcache is handed tag 4.
    Icache2mem_command = BUS_LOAD;
    Icache2mem_addr    = 32'h140;
    mem2proc_response  = 4'd4;
    tick();
    idle();
    Dcache2mem_command = BUS_LOAD;
    Dcache2mem_addr    = 32'h340;
    mem2proc_response  = 4'd4;
    mem2proc_tag       = 4'd4;
    #1;
    chk("reuse4_itag", 64'(Imem2proc_tag), 64'd4);
    chk("reuse4_dtag", 64'(Dmem2proc_tag), 64'd0);
    chk("reuse4_dresp", 64'(Dmem2proc_response), 64'd4);
    tick();
    idle();
    mem2proc_tag = 4'd4;
    #1;
    chk("own4_dtag", 64'(Dmem2proc_tag), 64'd4);
    chk("own4_itag", 64'(Imem2proc_tag), 64'd0);
    tick();
    idle();
    tick();

    // Rejected contention counts as denial: exactly three, so one more denial before icache wins.
    for (int k = 1; k <= 3; k++) begin
      both_load(4'd0);
      #1;
      chk($sformatf("rej%0d_addr", k), 64'(proc2mem_addr), 64'h300);
      chk($sformatf("rej%0d_dresp", k), 64'(Dmem2proc_response), 64'd0);
      tick();
    end
    both_load(4'd0);
    #1;
    chk("rej4_dcache", 64'(proc2mem_addr), 64'h300);
    tick();
    both_load(4'd0);
    #1;
    chk("rej5_icache", 64'(proc2mem_addr), 64'h108);
    tick();
    idle();
    mem2proc_tag = 4'd1;
    #1;
    chk("rej_no_entry_i", 64'(Imem2proc_tag), 64'd0);
    chk("rej_no_entry_d", 64'(Dmem2proc_tag), 64'd0);
    tick();
    idle();

    // Reset mid-cycle with tags 1 and 2 outstanding.
    Icache2mem_command = BUS_LOAD;
    Icache2mem_addr    = 32'h180;
    mem2proc_response  = 4'd1;
    tick();
    idle();
    Dcache2mem_command = BUS_LOAD;
    Dcache2mem_addr    = 32'h380;
    mem2proc_response  = 4'd2;
    tick();
    idle();
    mem2proc_tag = 4'd1;
    #1;
    chk("pre_rst_itag1", 64'(Imem2proc_tag), 64'd1);
    both_load(4'd6);
    #1;
    reset_n = 1'b0;
    #1;
    chk("inrst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("inrst_addr", 64'(proc2mem_addr), 64'h0);
    chk("inrst_iresp", 64'(Imem2proc_response), 64'd0);
    chk("inrst_dresp", 64'(Dmem2proc_response), 64'd0);
    chk("inrst_itag", 64'(Imem2proc_tag), 64'd0);
    tick();
    reset_n = 1'b1;
    idle();
    mem2proc_tag = 4'd1;
    #1;
    chk("post_rst_tag1_i", 64'(Imem2proc_tag), 64'd0);
    chk("post_rst_tag1_d", 64'(Dmem2proc_tag), 64'd0);
    tick();
    mem2proc_tag = 4'd2;
    #1;
    chk("post_rst_tag2_i", 64'(Imem2proc_tag), 64'd0);
    chk("post_rst_tag2_d", 64'(Dmem2proc_tag), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
